pic_interrupt_sequencer: RTL and testbench

Interrupt control core of the 8259A-style PIC. It owns the IRR, ISR and IMR registers and runs the priority resolver. It sequences the INT/INTA handshake that delivers an 8086-mode vector. It is configured by the write decodes from the read/write logic (WR_flag, WR_cur, Ds) and presents IRR/ISR/IMR for read-back through the data bus block.

---
 rtl/pic_interrupt_sequencer_if.sv | 33 +++
 rtl/pic_interrupt_sequencer.sv | 243 ++++++++++++++++++++++++
 tb/tb_pic_interrupt_sequencer.sv | 460 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pic_interrupt_sequencer_if.sv
// Bus-side signals of the PIC interrupt sequencer.
// Handshakes on this bundle:
// - A write is a level strobe. WR_flag is held high while WR_cur/Ds are valid.
//   The word commits once, shortly after WR_flag falls.
// - The CPU acknowledge is two active-low INTA_N pulses. The first pulse
//   latches the winning level. VEC is valid while VEC_OE is high, which
//   spans the low phase of the second pulse.
// - fsm_state exposes the sequencer state for debug and assertion binding.
interface pic_interrupt_sequencer_if;
  logic [7:0] IR;
  logic       INTA_N;
  logic       WR_flag;
  logic [2:0] WR_cur;
  logic [7:0] Ds;
  logic       NO_ICW4;
  logic       INT;
  logic [7:0] VEC;
  logic       VEC_OE;
  logic [7:0] IRR;
  logic [7:0] ISR;
  logic [7:0] IMR;
  logic [2:0] fsm_state;

  modport master (
    output IR, INTA_N, WR_flag, WR_cur, Ds, NO_ICW4,
    input  INT, VEC, VEC_OE, IRR, ISR, IMR, fsm_state
  );

  modport slave (
    input  IR, INTA_N, WR_flag, WR_cur, Ds, NO_ICW4,
    output INT, VEC, VEC_OE, IRR, ISR, IMR, fsm_state
  );
endinterface

// File: rtl/pic_interrupt_sequencer.sv
// Interrupt control core of an 8259A-style PIC (single, 8086 mode).
// Owns IRR/ISR/IMR, resolves priority, and sequences the INT/INTA handshake.
// Optional feature macro: PIC_ROTATE_EN (rotating priority through OCW2).
module pic_interrupt_sequencer #(
  parameter int SYNC_STAGES = 2
) (
  input logic CLK,
  input logic RST_N,
  pic_interrupt_sequencer_if.slave bus
);

  // At least two flops are always used, even if a smaller value is configured.
  localparam int STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  typedef enum logic [2:0] {IDLE, PEND, ACK1, WAIT2, ACK2} state_t;

  logic [STAGES-1:0][7:0] ir_sync;
  logic [STAGES-1:0]      inta_sync;
  logic [7:0] ir_s;
  logic       inta_s;

  logic       wr_q, wr_q_d;
  logic [2:0] cur_q;
  logic [7:0] ds_q;
  logic       commit;

  state_t     state;
  logic       int_q, vec_oe_q, spur_q;
  logic [7:0] vec_q, irr, isr, imr;
  logic [4:0] t_q;
  logic       ltim, aeoi;
  logic [2:0] id_q;
  logic [2:0] base;
  logic       inta_d;
  logic [7:0] ir_d;

  logic [7:0] irr_set, irr_upd;
  logic       inta_fall, inta_rise;
  logic [3:0] w_pick, s_pick;
  logic       w_found, s_found, req_valid;
  logic [2:0] w_id, s_id, w_rel, s_rel;
  logic [7:0] w_bit;

  // Highest-priority set bit of v, where level 'b' is highest. Returns {found, idx}.
  function automatic logic [3:0] pick(input logic [7:0] v, input logic [2:0] b);
    logic [3:0] r;
    logic [2:0] idx;
    r = 4'd0;
    for (int k = 7; k >= 0; k--) begin
      idx = b + k[2:0];
      if (v[idx]) r = {1'b1, idx};
    end
    return r;
  endfunction

  // Bring the asynchronous IR lines and INTA_N into the clock domain.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ir_sync   <= '0;
      inta_sync <= '1;
    end else begin
      ir_sync[0]   <= bus.IR;
      inta_sync[0] <= bus.INTA_N;
      for (int i = 1; i < STAGES; i++) begin
        ir_sync[i]   <= ir_sync[i-1];
        inta_sync[i] <= inta_sync[i-1];
      end
    end
  end

  assign ir_s   = ir_sync[STAGES-1];
  assign inta_s = inta_sync[STAGES-1];

  // Register the write strobe and hold the word/data seen while it was high.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_q   <= 1'b0;
      wr_q_d <= 1'b0;
      cur_q  <= 3'd0;
      ds_q   <= 8'd0;
    end else begin
      wr_q   <= bus.WR_flag;
      wr_q_d <= wr_q;
      if (bus.WR_flag) begin
        cur_q <= bus.WR_cur;
        ds_q  <= bus.Ds;
      end
    end
  end

  assign commit = wr_q_d & ~wr_q;

`ifndef PIC_ROTATE_EN
  assign base = 3'd0;
`endif

  // Edge mode latches rising edges, level mode follows the line. A request
  // that drops before it is acknowledged is always withdrawn.
  assign irr_set = ltim ? ir_s : (ir_s & ~ir_d);
  assign irr_upd = (irr | irr_set) & ir_s;

  // inta_d is frozen during a commit cycle, so the edge is still seen next cycle.
  assign inta_fall = inta_d & ~inta_s;
  assign inta_rise = ~inta_d & inta_s;

  // Priority resolver, with priorities measured relative to the base level.
  always_comb begin
    w_pick    = pick(irr & ~imr, base);
    s_pick    = pick(isr, base);
    w_found   = w_pick[3];
    w_id      = w_pick[2:0];
    s_found   = s_pick[3];
    s_id      = s_pick[2:0];
    w_rel     = w_id - base;
    s_rel     = s_id - base;
    w_bit     = 8'd1 << w_id;
    req_valid = w_found && (!s_found || (w_rel < s_rel));
  end

  // Control registers, IRR/ISR/IMR and the INT/INTA sequencer.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state    <= IDLE;
      int_q    <= 1'b0;
      vec_q    <= 8'd0;
      vec_oe_q <= 1'b0;
      spur_q   <= 1'b0;
      irr      <= 8'd0;
      isr      <= 8'd0;
      imr      <= 8'd0;
      t_q      <= 5'd0;
      ltim     <= 1'b0;
      aeoi     <= 1'b0;
      id_q     <= 3'd0;
      inta_d   <= 1'b1;
      ir_d     <= 8'd0;
`ifdef PIC_ROTATE_EN
      base     <= 3'd0;
`endif
    end else begin
      ir_d <= ir_s;
      irr  <= irr_upd;
      if (commit) begin
        case (cur_q)
          3'b000: begin
            ltim     <= ds_q[3];
            imr      <= 8'd0;
            isr      <= 8'd0;
            irr      <= 8'd0;
            aeoi     <= 1'b0;
            state    <= IDLE;
            int_q    <= 1'b0;
            vec_oe_q <= 1'b0;
`ifdef PIC_ROTATE_EN
            base     <= 3'd0;
`endif
          end
          3'b001: begin
            t_q <= ds_q[7:3];
            if (bus.NO_ICW4) aeoi <= 1'b0;
          end
          3'b011: aeoi <= ds_q[1];
          3'b100: imr  <= ds_q;
          3'b101: begin
            case (ds_q[7:5])
`ifdef PIC_ROTATE_EN
              3'b001: if (s_found) isr[s_id] <= 1'b0;
              3'b011: isr[ds_q[2:0]] <= 1'b0;
              3'b101: begin
                if (s_found) begin
                  isr[s_id] <= 1'b0;
                  base      <= s_id + 3'd1;
                end
              end
              3'b111: begin
                isr[ds_q[2:0]] <= 1'b0;
                base           <= ds_q[2:0] + 3'd1;
              end
              3'b110: base <= ds_q[2:0] + 3'd1;
`else
              3'b001, 3'b101: if (s_found) isr[s_id] <= 1'b0;
              3'b011, 3'b111: isr[ds_q[2:0]] <= 1'b0;
`endif
              default: ;
            endcase
          end
          default: ;
        endcase
      end else begin
        inta_d <= inta_s;
        case (state)
          IDLE, PEND: begin
            if (inta_fall) begin
              // First acknowledge: take the winner, or answer with level 7 if none.
              int_q <= 1'b0;
              state <= ACK1;
              if (req_valid) begin
                id_q   <= w_id;
                spur_q <= 1'b0;
                isr    <= isr | w_bit;
                irr    <= irr_upd & ~w_bit;
              end else begin
                id_q   <= 3'd7;
                spur_q <= 1'b1;
              end
            end else if (state == IDLE && req_valid) begin
              int_q <= 1'b1;
              state <= PEND;
            end else if (state == PEND && !req_valid) begin
              int_q <= 1'b0;
              state <= IDLE;
            end
          end
          ACK1: if (inta_rise) state <= WAIT2;
          WAIT2: begin
            if (inta_fall) begin
              vec_q    <= {t_q, id_q};
              vec_oe_q <= 1'b1;
              state    <= ACK2;
            end
          end
          ACK2: begin
            if (inta_rise) begin
              vec_oe_q <= 1'b0;
              if (aeoi && !spur_q) isr[id_q] <= 1'b0;
              state <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.INT       = int_q;
  assign bus.VEC       = vec_q;
  assign bus.VEC_OE    = vec_oe_q;
  assign bus.IRR       = irr;
  assign bus.ISR       = isr;
  assign bus.IMR       = imr;
  assign bus.fsm_state = state;

endmodule

// File: tb/tb_pic_interrupt_sequencer.sv
// Self-checking bench for pic_interrupt_sequencer (directed scenarios plus
// randomized requests/masks/EOIs checked against a transaction-level model).
module tb_pic_interrupt_sequencer;
  localparam int SYNC = 2;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  pic_interrupt_sequencer_if bus();

  pic_interrupt_sequencer #(.SYNC_STAGES(SYNC)) dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (bus)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state (register-level view of the controller)
  logic [7:0] m_irr, m_isr, m_imr;
  logic [4:0] m_t;
  logic       m_aeoi, m_ltim;
  int         m_base;

  function automatic int prio(input int lvl);
    return (lvl - m_base + 8) % 8;
  endfunction

  // Level of the highest-priority set bit, -1 if none.
  function automatic int top(input logic [7:0] v);
    int best;
    best = -1;
    for (int i = 0; i < 8; i++)
      if (v[i] && (best < 0 || prio(i) < prio(best))) best = i;
    return best;
  endfunction

  function automatic bit m_valid();
    int w, s;
    w = top(m_irr & ~m_imr);
    s = top(m_isr);
    return (w >= 0) && (s < 0 || prio(w) < prio(s));
  endfunction

  task automatic model_reset();
    m_irr = 0; m_isr = 0; m_imr = 0; m_t = 0; m_aeoi = 0; m_ltim = 0; m_base = 0;
  endtask

  task automatic model_write(input logic [2:0] cur, input logic [7:0] d);
    int s, l;
    s = top(m_isr);
    l = int'(d[2:0]);
    case (cur)
      3'd0: begin
        m_ltim = d[3]; m_imr = 0; m_isr = 0; m_irr = 0; m_base = 0; m_aeoi = 0;
      end
      3'd1: begin
        m_t = d[7:3];
        if (bus.NO_ICW4) m_aeoi = 0;
      end
      3'd3: m_aeoi = d[1];
      3'd4: m_imr = d;
      3'd5: begin
        case (d[7:5])
          3'b001: if (s >= 0) m_isr[s] = 1'b0;
          3'b011: m_isr[l] = 1'b0;
`ifdef PIC_ROTATE_EN
          3'b101: if (s >= 0) begin m_isr[s] = 1'b0; m_base = (s + 1) % 8; end
          3'b111: begin m_isr[l] = 1'b0; m_base = (l + 1) % 8; end
          3'b110: m_base = (l + 1) % 8;
`else
          3'b101: if (s >= 0) m_isr[s] = 1'b0;
          3'b111: m_isr[l] = 1'b0;
`endif
          default: ;
        endcase
      end
      default: ;
    endcase
  endtask

  // Driver tasks
  task automatic wr(input logic [2:0] cur, input logic [7:0] d);
    @(negedge clk);
    bus.WR_cur  = cur;
    bus.Ds      = d;
    bus.WR_flag = 1'b1;
    repeat (2) @(negedge clk);
    bus.WR_flag = 1'b0;
    repeat (4) @(negedge clk);
    model_write(cur, d);
  endtask

  task automatic init(input logic [7:0] icw1, input logic [7:0] icw2, input logic [7:0] icw4);
    wr(3'd0, icw1);
    wr(3'd1, icw2);
    wr(3'd3, icw4);
  endtask

  // One INTA_N pulse; VEC_OE/VEC are sampled late in the low phase.
  task automatic inta_pulse(output logic oe, output logic [7:0] vec);
    bus.INTA_N = 1'b0;
    repeat (4) @(negedge clk);
    oe  = bus.VEC_OE;
    vec = bus.VEC;
    bus.INTA_N = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic settle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Scenarios
  task automatic test_reset();
    n_checks++;
    if (bus.INT !== 1'b0 || bus.VEC !== 8'h00 || bus.VEC_OE !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: INT=%b VEC=%h VEC_OE=%b, want 0/00/0", bus.INT, bus.VEC, bus.VEC_OE);
    end
    n_checks++;
    if ({bus.IRR, bus.ISR, bus.IMR} !== 24'h0) begin
      n_fail++;
      $display("FAIL reset_regs: IRR=%h ISR=%h IMR=%h, want 00", bus.IRR, bus.ISR, bus.IMR);
    end
  endtask

  task automatic test_basic();
    int cnt;
    logic oe1, oe2;
    logic [7:0] v1, v2;
    init(8'h13, 8'h20, 8'h01);
    bus.IR = 8'h08;
    cnt = 0;
    while (bus.INT !== 1'b1 && cnt < 12) begin
      @(negedge clk);
      cnt++;
    end
    n_checks++;
    if (bus.INT !== 1'b1 || cnt > SYNC + 2) begin
      n_fail++;
      $display("FAIL basic_int_latency: INT=%b after %0d cycles, want 1 within %0d", bus.INT, cnt, SYNC + 2);
    end
    inta_pulse(oe1, v1);
    n_checks++;
    if (oe1 !== 1'b0 || bus.INT !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_first_inta: VEC_OE=%b INT=%b, want 0/0", oe1, bus.INT);
    end
    inta_pulse(oe2, v2);
    n_checks++;
    if (oe2 !== 1'b1 || v2 !== 8'h23) begin
      n_fail++;
      $display("FAIL basic_vector: VEC_OE=%b VEC=%h, want 1/23", oe2, v2);
    end
    n_checks++;
    if (bus.VEC_OE !== 1'b0 || bus.ISR !== 8'h08 || bus.IRR !== 8'h00) begin
      n_fail++;
      $display("FAIL basic_after_ack: VEC_OE=%b ISR=%h IRR=%h, want 0/08/00", bus.VEC_OE, bus.ISR, bus.IRR);
    end
    bus.IR = 8'h00;
    wr(3'd5, 8'h20);
    n_checks++;
    if (bus.ISR !== 8'h00) begin
      n_fail++;
      $display("FAIL basic_eoi: ISR=%h, want 00", bus.ISR);
    end
  endtask

  task automatic test_nesting();
    logic oe;
    logic [7:0] v;
    bus.IR = 8'h20;
    settle(6);
    inta_pulse(oe, v);
    inta_pulse(oe, v);
    n_checks++;
    if (v !== 8'h25 || bus.ISR !== 8'h20) begin
      n_fail++;
      $display("FAIL nest_first: VEC=%h ISR=%h, want 25/20", v, bus.ISR);
    end
    bus.IR = 8'h40;
    settle(8);
    n_checks++;
    if (bus.INT !== 1'b0 || bus.IRR !== 8'h40) begin
      n_fail++;
      $display("FAIL nest_lower_blocked: INT=%b IRR=%h, want 0/40", bus.INT, bus.IRR);
    end
    bus.IR = 8'h44;
    settle(6);
    n_checks++;
    if (bus.INT !== 1'b1) begin
      n_fail++;
      $display("FAIL nest_higher_int: INT=%b, want 1", bus.INT);
    end
    inta_pulse(oe, v);
    inta_pulse(oe, v);
    n_checks++;
    if (v !== 8'h22 || bus.ISR !== 8'h24) begin
      n_fail++;
      $display("FAIL nest_second: VEC=%h ISR=%h, want 22/24", v, bus.ISR);
    end
    bus.IR = 8'h00;
    settle(4);
    wr(3'd5, 8'h20);
    n_checks++;
    if (bus.ISR !== 8'h20) begin
      n_fail++;
      $display("FAIL nest_eoi1: ISR=%h, want 20", bus.ISR);
    end
    wr(3'd5, 8'h20);
    n_checks++;
    if (bus.ISR !== 8'h00) begin
      n_fail++;
      $display("FAIL nest_eoi2: ISR=%h, want 00", bus.ISR);
    end
  endtask

  task automatic test_masking();
    logic oe;
    logic [7:0] v;
    wr(3'd4, 8'h08);
    bus.IR = 8'h08;
    settle(8);
    n_checks++;
    if (bus.IRR !== 8'h08 || bus.INT !== 1'b0 || bus.IMR !== 8'h08) begin
      n_fail++;
      $display("FAIL mask_hold: IRR=%h INT=%b IMR=%h, want 08/0/08", bus.IRR, bus.INT, bus.IMR);
    end
    wr(3'd4, 8'h00);
    n_checks++;
    if (bus.INT !== 1'b1) begin
      n_fail++;
      $display("FAIL mask_release: INT=%b, want 1", bus.INT);
    end
    inta_pulse(oe, v);
    inta_pulse(oe, v);
    n_checks++;
    if (v !== 8'h23) begin
      n_fail++;
      $display("FAIL mask_vector: VEC=%h, want 23", v);
    end
    bus.IR = 8'h00;
    wr(3'd5, 8'h20);
  endtask

  task automatic test_spurious_level();
    logic oe;
    logic [7:0] v;
    init(8'h1B, 8'h20, 8'h01);
    bus.IR = 8'h10;
    settle(6);
    n_checks++;
    if (bus.INT !== 1'b1 || bus.IRR !== 8'h10) begin
      n_fail++;
      $display("FAIL level_int: INT=%b IRR=%h, want 1/10", bus.INT, bus.IRR);
    end
    bus.IR = 8'h00;
    settle(6);
    n_checks++;
    if (bus.INT !== 1'b0 || bus.IRR !== 8'h00) begin
      n_fail++;
      $display("FAIL level_withdraw: INT=%b IRR=%h, want 0/00", bus.INT, bus.IRR);
    end
    inta_pulse(oe, v);
    inta_pulse(oe, v);
    n_checks++;
    if (oe !== 1'b1 || v !== 8'h27 || bus.ISR !== 8'h00) begin
      n_fail++;
      $display("FAIL spurious_vector: VEC_OE=%b VEC=%h ISR=%h, want 1/27/00", oe, v, bus.ISR);
    end
  endtask

  task automatic test_aeoi_reset();
    logic oe;
    logic [7:0] v;
    init(8'h13, 8'h20, 8'h03);
    bus.IR = 8'h02;
    settle(6);
    inta_pulse(oe, v);
    n_checks++;
    if (bus.ISR !== 8'h02) begin
      n_fail++;
      $display("FAIL aeoi_in_service: ISR=%h, want 02", bus.ISR);
    end
    bus.IR = 8'h00;
    inta_pulse(oe, v);
    n_checks++;
    if (v !== 8'h21 || bus.ISR !== 8'h00) begin
      n_fail++;
      $display("FAIL aeoi_auto_clear: VEC=%h ISR=%h, want 21/00", v, bus.ISR);
    end
    wr(3'd4, 8'h01);
    bus.IR = 8'h20;
    settle(6);
    inta_pulse(oe, v);
    // Sequencer is now waiting for the second acknowledge pulse.
    #3;
    rst_n  = 1'b0;
    bus.IR = 8'h00;
    #1;
    n_checks++;
    if (bus.INT !== 1'b0 || bus.VEC_OE !== 1'b0 || bus.VEC !== 8'h00 ||
        {bus.IRR, bus.ISR, bus.IMR} !== 24'h0) begin
      n_fail++;
      $display("FAIL reset_mid_seq: INT=%b VEC_OE=%b VEC=%h IRR=%h ISR=%h IMR=%h, want all 0",
               bus.INT, bus.VEC_OE, bus.VEC, bus.IRR, bus.ISR, bus.IMR);
    end
    settle(2);
    rst_n = 1'b1;
    model_reset();
    settle(2);
  endtask

  task automatic test_icw1_mid();
    logic oe;
    logic [7:0] v;
    init(8'h13, 8'h20, 8'h01);
    bus.IR = 8'h08;
    settle(6);
    inta_pulse(oe, v);
    bus.INTA_N = 1'b0;
    settle(4);
    n_checks++;
    if (bus.VEC_OE !== 1'b1) begin
      n_fail++;
      $display("FAIL icw1_mid_pre: VEC_OE=%b, want 1", bus.VEC_OE);
    end
    wr(3'd0, 8'h13);
    n_checks++;
    if (bus.VEC_OE !== 1'b0 || bus.ISR !== 8'h00 || bus.INT !== 1'b0) begin
      n_fail++;
      $display("FAIL icw1_mid_abort: VEC_OE=%b ISR=%h INT=%b, want 0/00/0", bus.VEC_OE, bus.ISR, bus.INT);
    end
    bus.INTA_N = 1'b1;
    bus.IR     = 8'h00;
    settle(6);
    wr(3'd1, 8'h20);
    wr(3'd3, 8'h01);
  endtask

  task automatic test_rotate();
    logic oe;
    logic [7:0] v, ev, eisr;
    init(8'h13, 8'h20, 8'h01);
    wr(3'd4, 8'hFF);
    bus.IR = 8'h81;
    settle(6);
    wr(3'd5, 8'hC6);
    wr(3'd4, 8'h00);
    inta_pulse(oe, v);
    inta_pulse(oe, v);
`ifdef PIC_ROTATE_EN
    ev = 8'h27; eisr = 8'h80;
`else
    ev = 8'h20; eisr = 8'h01;
`endif
    n_checks++;
    if (v !== ev || bus.ISR !== eisr) begin
      n_fail++;
      $display("FAIL rotate_order: VEC=%h ISR=%h, want %h/%h", v, bus.ISR, ev, eisr);
    end
    bus.IR = 8'h00;
    settle(4);
    wr(3'd5, 8'h20);
    n_checks++;
    if (bus.ISR !== 8'h00) begin
      n_fail++;
      $display("FAIL rotate_eoi: ISR=%h, want 00", bus.ISR);
    end
  endtask

  task automatic test_random();
    logic oe;
    logic [7:0] v, p, d, ev;
    logic exp_int;
    int w, s, sel;
    init(8'h13, 8'h20 | 8'($urandom_range(0, 31) << 3), ($urandom_range(0, 1) != 0) ? 8'h03 : 8'h01);
    for (int it = 0; it < 30; it++) begin
      wr(3'd4, 8'($urandom & $urandom));
      p = 8'($urandom_range(1, 255));
      bus.IR = p;
      m_irr  = p;
      settle(8);
      exp_int = m_valid();
      n_checks++;
      if (bus.INT !== exp_int || bus.IRR !== m_irr) begin
        n_fail++;
        $display("FAIL rand_req it=%0d: INT=%b IRR=%h, want %b/%h", it, bus.INT, bus.IRR, exp_int, m_irr);
      end
      if (exp_int) begin
        w = top(m_irr & ~m_imr);
        inta_pulse(oe, v);
        inta_pulse(oe, v);
        ev = {m_t, w[2:0]};
        m_irr[w] = 1'b0;
        if (!m_aeoi) m_isr[w] = 1'b1;
        n_checks++;
        if (oe !== 1'b1 || v !== ev || bus.ISR !== m_isr || bus.IRR !== m_irr) begin
          n_fail++;
          $display("FAIL rand_ack it=%0d: VEC_OE=%b VEC=%h ISR=%h IRR=%h, want 1/%h/%h/%h",
                   it, oe, v, bus.ISR, bus.IRR, ev, m_isr, m_irr);
        end
      end
      bus.IR = 8'h00;
      m_irr  = 8'h00;
      settle(6);
      s = top(m_isr);
      if (s < 0) s = $urandom_range(0, 7);
      sel = $urandom_range(0, 4);
      case (sel)
        0: d = 8'h20;
        1: d = 8'h60 | 8'(s);
        2: d = 8'hA0;
        3: d = 8'hE0 | 8'(s);
        default: d = 8'hC0 | 8'($urandom_range(0, 7));
      endcase
      wr(3'd5, d);
      n_checks++;
      if (bus.ISR !== m_isr || bus.INT !== 1'b0) begin
        n_fail++;
        $display("FAIL rand_eoi it=%0d ocw2=%h: ISR=%h INT=%b, want %h/0", it, d, bus.ISR, bus.INT, m_isr);
      end
    end
  endtask

  // Main sequence and final report
  initial begin
    n_checks    = 0;
    n_fail      = 0;
    rst_n       = 1'b0;
    bus.IR      = 8'h00;
    bus.INTA_N  = 1'b1;
    bus.WR_flag = 1'b0;
    bus.WR_cur  = 3'd0;
    bus.Ds      = 8'h00;
    bus.NO_ICW4 = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    settle(2);
    test_reset();
    test_basic();
    test_nesting();
    test_masking();
    test_spurious_level();
    test_aeoi_reset();
    test_icw1_mid();
    test_rotate();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
